imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Writer side of the instruction-memory fetch path. Receives a byte stream over a valid/ready
//  handshake, packs bytes into WORD_W instruction words and writes them sequentially into
//  instruction memory from address 0. Holds the processor core in reset until a complete,
//  checksum-verified image has been written.
// PARAMETERS
//  ADDR_W     10    instruction address width (matches program counter width)
//  WORD_W     16    instruction word width (two bytes per word)
//  MAX_WORDS  1024  largest accepted image length, in words
// PORTS
//  clk           in   1        system clock; all logic on rising edge
//  reset         in   1        synchronous, active-high reset
//  in_data       in   8        incoming stream byte
//  in_valid      in   1        in_data is valid
//  in_ready      out  1        loader can accept a byte; byte transfers when in_valid & in_ready
//  imem_wr_en    out  1        one-cycle instruction-memory write strobe
//  imem_wr_addr  out  ADDR_W   write word address
//  imem_wr_data  out  WORD_W   write word {high byte, low byte}
//  core_hold     out  1        drives the core's reset; 1 = core held
//  load_done     out  1        image loaded and verified
//  load_err      out  1        bad length or checksum mismatch
//  words_loaded  out  ADDR_W+1 count of words written in the current load
// BEHAVIOUR
//  Reset values: in_ready=0 for the reset cycle, then 1 in IDLE. imem_wr_en=0, imem_wr_addr=0,
//   imem_wr_data=0, core_hold=1, load_done=0, load_err=0, words_loaded=0. State=IDLE.
//  Frame: 0xA5 sync, LEN_LO, LEN_HI (word count N, little-endian), 2N payload bytes
//   (low byte then high byte per word), CHK. CHK = sum of the 2N payload bytes mod 256.
//  Throughput: one byte accepted per cycle. in_ready=1 in every state except DONE.
//  States:
//   IDLE    - non-0xA5 bytes are discarded; 0xA5 -> LEN_LO; clear words_loaded, sum, addr.
//   LEN_LO  - latch N[7:0] -> LEN_HI.
//   LEN_HI  - latch N[15:8]; N==0 or N>MAX_WORDS -> ERROR, else -> DATA_LO.
//   DATA_LO - latch low byte, add to sum -> DATA_HI.
//   DATA_HI - add to sum; next cycle: imem_wr_en=1 with addr=word index and data={hi,lo};
//             addr and words_loaded increment with the strobe; last word -> CHECK, else DATA_LO.
//   CHECK   - CHK==sum -> DONE, else -> ERROR.
//   DONE    - load_done=1, core_hold=0 the cycle after CHK is accepted; in_ready=0;
//             remains until reset.
//   ERROR   - load_err=1, core_hold=1; a 0xA5 byte clears load_err and restarts at LEN_LO;
//             other bytes are discarded.
//  Write latency: exactly 1 cycle from acceptance of the high byte to imem_wr_en. The strobe
//   for word k is never merged or dropped, even when the next low byte arrives in the same cycle.
//  Gaps in in_valid at any point stall the FSM without timeout; state and partial word are held.
//  Memory already written before an ERROR is not scrubbed. core_hold stays 1 until DONE.
//  Reset mid-load aborts at once: state=IDLE, all outputs return to reset values; any pending
//   write strobe is cancelled.
//  imem_wr_addr wraps nowhere: N<=MAX_WORDS<=2^ADDR_W bounds the address.
// TESTING
//  1. Stream A5 02 00 34 12 78 56 14 -> writes (0,0x1234), (1,0x5678); load_done=1, core_hold=0.
//  2. Same frame with CHK=0x15 -> both writes occur, then load_err=1, core_hold=1. Follow with a
//     valid frame -> load_err clears, load_done=1.
//  3. LEN=0x0000 and LEN=0x0401 -> ERROR right after LEN_HI, no imem_wr_en pulses.
//  4. Bytes 00 FF A5 01 00 CD AB 78 with random in_valid gaps -> single write (0,0xABCD) and
//     load_done=1.
//  5. Assert reset after the 3rd payload byte -> all outputs at reset values the next cycle;
//     no write strobe; a fresh frame then loads correctly.
//  6. N=1024, payload bytes 0x00..0xFF repeating, back-to-back -> 1024 strobes, last at addr
//     1023; words_loaded=1024; load_done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory. Packs a framed byte stream into instruction words,
// writes them from address 0 upward and keeps the core in reset until the whole image has
// been written and its checksum matches.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [WORD_W-1:0] imem_wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [7:0]    SyncByte = 8'hA5;
  localparam logic [15:0]   MaxLen   = 16'(MAX_WORDS);
  localparam logic [ADDR_W:0] CntOne = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StDataLo,
    StDataHi,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e      state_q;
  logic [15:0] len_q;
  logic [7:0]  lo_q;
  logic [7:0]  sum_q;

  logic        accept;
  logic [15:0] len_full;
  logic [7:0]  sum_next;
  logic        last_word;

  // Decode of the current byte against the held frame context.
  always_comb begin
    accept    = in_valid & in_ready;
    len_full  = {in_data, len_q[7:0]};
    sum_next  = sum_q + in_data;
    // words_loaded still holds the count before this word's strobe.
    last_word = (16'(words_loaded) + 16'd1) == len_q;
  end

  // Frame FSM with all outputs registered; reset wins over any pending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      lo_q         <= '0;
      sum_q        <= '0;
      in_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_wr_en <= 1'b0;
      in_ready   <= (state_q != StDone);
      if (accept) begin
        case (state_q)
          StIdle: begin
            if (in_data == SyncByte) begin
              state_q      <= StLenLo;
              words_loaded <= '0;
              sum_q        <= '0;
              imem_wr_addr <= '0;
            end
          end
          StLenLo: begin
            len_q[7:0] <= in_data;
            state_q    <= StLenHi;
          end
          StLenHi: begin
            len_q[15:8] <= in_data;
            if (len_full == 16'd0 || len_full > MaxLen) begin
              state_q  <= StError;
              load_err <= 1'b1;
            end else begin
              state_q <= StDataLo;
            end
          end
          StDataLo: begin
            lo_q    <= in_data;
            sum_q   <= sum_next;
            state_q <= StDataHi;
          end
          StDataHi: begin
            sum_q        <= sum_next;
            imem_wr_en   <= 1'b1;
            imem_wr_addr <= words_loaded[ADDR_W-1:0];
            imem_wr_data <= WORD_W'({in_data, lo_q});
            words_loaded <= words_loaded + CntOne;
            state_q      <= last_word ? StCheck : StDataLo;
          end
          StCheck: begin
            if (in_data == sum_q) begin
              state_q   <= StDone;
              load_done <= 1'b1;
              core_hold <= 1'b0;
              in_ready  <= 1'b0;
            end else begin
              state_q  <= StError;
              load_err <= 1'b1;
            end
          end
          StDone: begin
            // in_ready is low here, so nothing is ever accepted.
          end
          StError: begin
            // A new sync byte restarts directly at the length field.
            if (in_data == SyncByte) begin
              state_q      <= StLenLo;
              load_err     <= 1'b0;
              words_loaded <= '0;
              sum_q        <= '0;
              imem_wr_addr <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: expected memory writes go into a scoreboard queue when frames
// are issued; a negedge monitor pops and compares on every write strobe.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [WORD_W-1:0] imem_wr_data;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W),
    .MAX_WORDS(1024)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .core_hold   (core_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_strobes = 0;
  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  logic [ADDR_W+WORD_W-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int addr, input logic [15:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 imem_wr_addr, imem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_wr_addr), 32'(mon_e[ADDR_W+WORD_W-1:WORD_W]));
        chk("wr_data", 32'(imem_wr_data), 32'(mon_e[WORD_W-1:0]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the byte.
  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    int waited;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    waited = 0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) begin
        waited++;
        if (waited > 50) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: byte 0x%0h not accepted, in_ready=%0b, expected 1",
                   b, in_ready);
          ok = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Sends the n right-justified bytes of 'bytes', most significant first.
  task automatic frame(input logic [63:0] bytes, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      send(bytes[8*(n-1-i) +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(imem_wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(imem_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(imem_wr_data), 32'd0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    @(negedge clk);
    chk({tag, "_load_done"}, 32'(load_done), 32'(done));
    chk({tag, "_load_err"}, 32'(load_err), 32'(err));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(!done));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(!done));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes_before;

    do_reset("rst0");

    // 1: two-word image, good checksum.
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    frame(64'hA502_0034_1278_5614, 8, 0);
    check_status("t1", 1'b1, 1'b0);
    chk("t1_words", 32'(words_loaded), 32'd2);

    // 2: bad checksum, then a good frame without reset.
    do_reset("rst2");
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    frame(64'hA502_0034_1278_5615, 8, 0);
    check_status("t2_bad", 1'b0, 1'b1);
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    frame(64'hA502_0034_1278_5614, 8, 0);
    check_status("t2_good", 1'b1, 1'b0);

    // 3: zero length and over-length images are rejected with no writes.
    do_reset("rst3");
    strobes_before = n_strobes;
    frame(64'hA50000, 3, 0);
    check_status("t3_len0", 1'b0, 1'b1);
    send(8'h11, 0);
    chk("t3_err_discard", 32'(load_err), 32'd1);
    send(8'hA5, 0);
    chk("t3_err_clear", 32'(load_err), 32'd0);
    frame(64'h0104, 2, 0);
    check_status("t3_len1025", 1'b0, 1'b1);
    chk("t3_no_strobes", 32'(n_strobes - strobes_before), 32'd0);

    // 4: leading junk and random in_valid gaps.
    do_reset("rst4");
    push_wr(0, 16'hABCD);
    frame(64'h00FF_A501_00CD_AB78, 8, 3);
    check_status("t4", 1'b1, 1'b0);

    // 5: reset after the third payload byte aborts the load.
    do_reset("rst5a");
    push_wr(0, 16'h1234);
    frame(64'hA502_0034_1278, 6, 0);
    strobes_before = n_strobes;
    do_reset("t5_abort");
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_strobe", 32'(n_strobes - strobes_before), 32'd0);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    push_wr(0, 16'h1234);
    push_wr(1, 16'h5678);
    frame(64'hA502_0034_1278_5614, 8, 0);
    check_status("t5_reload", 1'b1, 1'b0);

    // 6: maximum image, bytes 0x00..0xFF repeating; checksum works out to 0x00.
    do_reset("rst6");
    strobes_before = n_strobes;
    for (int k = 0; k < 1024; k++) begin
      push_wr(k, {8'((2 * k + 1) & 255), 8'((2 * k) & 255)});
    end
    frame(64'hA50004, 3, 0);
    for (int i = 0; i < 2048; i++) begin
      send(8'(i & 255), 0);
    end
    send(8'h00, 0);
    check_status("t6", 1'b1, 1'b0);
    chk("t6_words", 32'(words_loaded), 32'd1024);
    chk("t6_strobes", 32'(n_strobes - strobes_before), 32'd1024);
    chk("t6_last_addr", 32'(imem_wr_addr), 32'd1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
